alu_operand_fetch: RTL

Upstream operand stage for the 16-bit ALU. Holds the 8-entry general register file, fetches the two source operands through its single read port in two consecutive cycles, and applies the B-path shifter and the A/B source selects. It then presents a stable Ain/Bin/ALUop bundle to the ALU under a valid/ack handshake. Writeback from the downstream result register enters through the write port.

---
 rtl/alu_operand_fetch.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_operand_fetch.sv
// Operand fetch stage for the 16-bit ALU: 8-entry register file, two-cycle
// operand read through one port, B-path shifter and A/B source selects.
module alu_operand_fetch #(
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write,
    input  logic [2:0]            writenum,
    input  logic [data_width-1:0] data_in,
    input  logic                  start,
    input  logic [2:0]            rn,
    input  logic [2:0]            rm,
    input  logic [1:0]            shift,
    input  logic                  asel,
    input  logic                  bsel,
    input  logic [data_width-1:0] sximm5,
    input  logic [1:0]            ALUop_in,
    input  logic                  ack,
    output logic [data_width-1:0] Ain,
    output logic [data_width-1:0] Bin,
    output logic [1:0]            ALUop,
    output logic                  valid,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, RD_A, RD_B, VALID} state_t;

    state_t                state, state_next;
    logic                  load_cmd;

    logic [data_width-1:0] regs [8];
    logic [data_width-1:0] a_reg, b_reg;

    logic [2:0]            rn_q, rm_q;
    logic [1:0]            shift_q;
    logic                  asel_q, bsel_q;
    logic [data_width-1:0] sximm5_q;
    logic [1:0]            aluop_q;

    logic [2:0]            rd_idx;
    logic [data_width-1:0] rd_data;

    function automatic logic [data_width-1:0] shift_b(
        input logic [data_width-1:0] v,
        input logic [1:0]            sh
    );
        case (sh)
            2'b01:   shift_b = {v[data_width-2:0], 1'b0};
            2'b10:   shift_b = {1'b0, v[data_width-1:1]};
            2'b11:   shift_b = {v[data_width-1], v[data_width-1:1]};
            default: shift_b = v;
        endcase
    endfunction

    // Single read port: RD_A reads rn, every other state points at rm.
    // A same-cycle write to the addressed register is forwarded.
    always_comb begin
        rd_idx  = (state == RD_A) ? rn_q : rm_q;
        rd_data = (write && (writenum == rd_idx)) ? data_in : regs[rd_idx];
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        load_cmd   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_cmd   = 1'b1;
                    state_next = RD_A;
                end
            end
            RD_A:  state_next = RD_B;
            RD_B:  state_next = VALID;
            VALID: begin
                if (ack) begin
                    if (start) begin
                        load_cmd   = 1'b1;
                        state_next = RD_A;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the register file is an architectural state that must read zero
    // after reset, so it is reset here rather than left as an uninitialised RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (write) begin
            regs[writenum] <= data_in;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            rn_q     <= '0;
            rm_q     <= '0;
            shift_q  <= '0;
            asel_q   <= 1'b0;
            bsel_q   <= 1'b0;
            sximm5_q <= '0;
            aluop_q  <= '0;
        end else begin
            state <= state_next;
            if (load_cmd) begin
                rn_q     <= rn;
                rm_q     <= rm;
                shift_q  <= shift;
                asel_q   <= asel;
                bsel_q   <= bsel;
                sximm5_q <= sximm5;
                aluop_q  <= ALUop_in;
            end
            if (state == RD_A) a_reg <= rd_data;
            if (state == RD_B) b_reg <= shift_b(rd_data, shift_q);
        end
    end

    assign Ain   = asel_q ? '0 : a_reg;
    assign Bin   = bsel_q ? sximm5_q : b_reg;
    assign ALUop = aluop_q;
    assign valid = (state == VALID);
    assign busy  = (state != IDLE);

endmodule
